mac_feeder: RTL and testbench
=============================

# mac_feeder

Sequencer on the driving side of the MAC accumulator. It accepts operand pairs from upstream over a valid/ready handshake and runs one dot product of VECTOR_LEN pairs: clear, stream, drain. It drives the MAC's enable, clear and operand inputs, captures the accumulated result, and holds a done flag for the display/LED logic.

## Interface
- DATA_WIDTH, 8, operand width; MAC result width is 3*DATA_WIDTH.
- VECTOR_LEN, 8, pairs per dot product; must be ≥1.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a dot product; honoured only in IDLE or DONE.
- a_in  in  DATA_WIDTH  upstream operand A.
- b_in  in  DATA_WIDTH  upstream operand B.
- in_valid  in  1  upstream pair valid.
- in_ready  out  1  feeder accepts a pair this cycle.
- mac_en  out  1  to MAC En, registered.
- mac_clr  out  1  to MAC Clr, registered.
- mac_a  out  DATA_WIDTH  to MAC Ain, registered.
- mac_b  out  DATA_WIDTH  to MAC Bin, registered.
- mac_cout  in  3*DATA_WIDTH  from MAC Cout.
- result  out  3*DATA_WIDTH  captured dot product, stable in DONE.
- done  out  1  result valid (drives LED1).
- busy  out  1  high in CLEAR, RUN and DRAIN.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: in_ready=0, outputs idle. start=1 -> CLEAR.
- CLEAR: one cycle. Registers mac_clr=1 for exactly one cycle. Clears the beat counter and the drain counter. -> RUN.
- RUN: in_ready=1. A beat is in_valid & in_ready. On a beat, next cycle has mac_en=1, mac_a=a_in, mac_b=b_in. With no beat, mac_en=0 and mac_a/mac_b hold. Increments the beat counter. The beat that brings the count to VECTOR_LEN moves the FSM to DRAIN.
- DRAIN: in_ready=0. Waits 2 cycles: the registered last mac_en, then the MAC update. On the second cycle, result<=mac_cout. -> DONE.
- DONE: done=1; result holds. start=1 clears done, resets result to 0 -> CLEAR.
- start in CLEAR/RUN/DRAIN is ignored (no restart, no abort).
- Arithmetic is performed in the MAC. The feeder only counts and never truncates. Max result (2^DW−1)^2·VECTOR_LEN must fit in 3*DW bits; DW=8, LEN=8 gives 520200 (0x07F008).
- Beat counter width is $clog2(VECTOR_LEN+1). It never wraps within a run.

## Timing
- Reset values: in_ready=0, mac_en=0, mac_clr=0, mac_a=0, mac_b=0, result=0, done=0, busy=0; state=IDLE.
- rst mid-operation: next cycle all outputs are at reset values. Any beat in flight is dropped. The MAC is not cleared by the feeder until the next CLEAR.
- Latency from start (cycle t) to first possible accept:
  - mac_clr high in t+2.
  - in_ready high in t+2; accept is possible at t+2.
- Last beat at cycle u:
  - mac_en high at u+1.
  - result and done valid at u+3.
- With no bubbles: done at t+VECTOR_LEN+4.
- Upstream must hold a_in/b_in stable while in_valid=1 and in_ready=0. The feeder never drops a pair presented while in_ready=1.
- mac_en and mac_clr are never high in the same cycle.

## Structure
- Package mac_pkg:
  - typedef enum for feeder state (IDLE, CLEAR, RUN, DRAIN, DONE).
  - localparam ACC_WIDTH = 3*DATA_WIDTH helper; shared with the MAC.
- One sub-module: beat_counter. Counter with clear, increment and terminal-count output, parameterised by VECTOR_LEN.
- Top level instantiates only the FSM and beat_counter. The MAC is a sibling, wired in the parent.

## Test plan
- Nominal: A=1..8, B=1..8, in_valid always 1 → result=204 (0xCC), done at start+12, exactly 8 mac_en pulses, one mac_clr pulse.
- Bubbles: same vectors, in_valid toggling 1,0 each cycle → result=204, 8 mac_en pulses, mac_a/mac_b hold during gaps.
- Overflow bound: A=B=255 ×8 → result=0x07F008, no truncation.
- Restart: after DONE with 204, start then A=2×8, B=3×8 → mac_clr pulse precedes first mac_en; result=48, done low during run.
- Ignored start: start pulsed mid-RUN at beat 4 → no extra mac_clr, result still 204.
- Reset mid-run: rst at beat 5 → next cycle all outputs 0, state IDLE; new start then nominal vectors → 204.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// rtl/mac_feeder_pkg.sv - shared types and widths for the MAC feeder and its MAC sibling
package mac_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH      = 3 * DATA_WIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

  // Accumulator width for a given operand width; the MAC uses the same rule.
  function automatic int acc_width(input int dw);
    return 3 * dw;
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// rtl/mac_feeder_if.sv - upstream operand-pair handshake into the feeder
interface mac_feeder_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  in_valid;
  logic                  in_ready;

  modport master (
    output a_in,
    output b_in,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  a_in,
    input  b_in,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/mac_feeder_beat_counter.sv
// rtl/mac_feeder_beat_counter.sv - counts accepted pairs and flags the final beat
module beat_counter #(
  parameter int VECTOR_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(VECTOR_LEN + 1);
  localparam logic [CW-1:0] LAST_VAL = CW'(VECTOR_LEN - 1);

  logic [CW-1:0] count;

  // Count beats; the width holds VECTOR_LEN so the count never wraps within a run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // The increment that brings the count to VECTOR_LEN is the last beat.
  assign last = inc && (count == LAST_VAL);

endmodule

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - clear/stream/drain sequencer that feeds one dot product into the MAC
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VECTOR_LEN = 8,
  localparam int AW        = acc_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mac_feeder_if.slave           up,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [AW-1:0]         mac_cout,
  output logic [AW-1:0]         result,
  output logic                  done,
  output logic                  busy
);

  feeder_state_t state;
  logic          in_ready_q;
  logic          drain_cnt;
  logic          beat;
  logic          last_beat;

  assign up.in_ready = in_ready_q;

  // in_ready is only ever high in RUN, so a handshake implies RUN.
  assign beat = up.in_valid && in_ready_q;

  beat_counter #(
    .VECTOR_LEN(VECTOR_LEN)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == CLEAR),
    .inc  (beat),
    .last (last_beat)
  );

  // Sequencer: every MAC-facing output is registered so En/Clr see clean edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      drain_cnt  <= 1'b0;
    end else begin
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          mac_clr    <= 1'b1;
          drain_cnt  <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (beat) begin
            mac_en <= 1'b1;
            mac_a  <= up.a_in;
            mac_b  <= up.b_in;
            if (last_beat) begin
              in_ready_q <= 1'b0;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // First cycle carries the last registered En; the MAC has updated by the second.
          if (drain_cnt) begin
            result <= mac_cout;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            done   <= 1'b0;
            result <= '0;
            busy   <= 1'b1;
            state  <= CLEAR;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - directed self-checking bench for mac_feeder with a behavioural MAC
module tb_mac_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mac_en;
  logic        mac_clr;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [23:0] mac_cout;
  logic [23:0] result;
  logic        done;
  logic        busy;

  mac_feeder_if #(.DATA_WIDTH(8)) up ();

  mac_feeder #(
    .DATA_WIDTH(8),
    .VECTOR_LEN(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .up       (up),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_cout (mac_cout),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int clr_total = 0;
  int last_clr_cyc = -1;
  int first_en_cyc = -1;
  int en_since_clr = 0;
  int both_hi = 0;
  int hold_errs = 0;
  int done_in_run = 0;
  logic [23:0] acc = '0;
  logic [7:0]  va [8];
  logic [7:0]  vb [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number of the current clock period.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC sibling: clear wins, otherwise accumulate when enabled.
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + 24'(mac_a) * 24'(mac_b);
  end
  assign mac_cout = acc;

  // Pulse bookkeeping sampled mid-cycle.
  always @(negedge clk) begin
    if (mac_en && mac_clr) both_hi <= both_hi + 1;
    if (mac_clr) begin
      clr_total    <= clr_total + 1;
      last_clr_cyc <= cyc;
      en_since_clr <= 0;
    end else if (mac_en) begin
      if (en_since_clr == 0) first_en_cyc <= cyc;
      en_since_clr <= en_since_clr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start(output int c0);
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input bit bubbles, input int start_at, input int rst_at);
    int idx;
    int n;
    bit beat;
    bit fired;
    idx = 0;
    n = 0;
    fired = 0;
    while (idx < 8 && n < 60) begin
      up.in_valid = bubbles ? ~n[0] : 1'b1;
      up.a_in = va[idx];
      up.b_in = vb[idx];
      if (start_at >= 0 && idx == start_at && !fired) begin
        start = 1'b1;
        fired = 1;
      end
      if (rst_at >= 0 && idx == rst_at) rst = 1'b1;
      if (done === 1'b1) done_in_run++;
      if (idx > 0 && mac_en === 1'b0 && (mac_a !== va[idx-1] || mac_b !== vb[idx-1])) hold_errs++;
      beat = up.in_valid && up.in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (rst) return;
      if (beat) idx++;
    end
    check("feed_complete", 32'(idx), 32'd8);
    up.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    dc = cyc;
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) begin
      va[i] = 8'(i + 1);
      vb[i] = 8'(i + 1);
    end
  endtask

  initial begin
    int c0;
    int dc;
    int clr0;
    int dir0;
    int hold0;

    rst = 1'b1;
    start = 1'b0;
    up.in_valid = 1'b0;
    up.a_in = '0;
    up.b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(up.in_ready), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_mac_clr", 32'(mac_clr), 32'd0);
    check("rst_mac_a", 32'(mac_a), 32'd0);
    check("rst_mac_b", 32'(mac_b), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal ramp, no bubbles.
    load_ramp();
    clr0 = clr_total;
    pulse_start(c0);
    check("nom_busy_t1", 32'(busy), 32'd1);
    check("nom_ready_t1", 32'(up.in_ready), 32'd0);
    check("nom_clr_t1", 32'(mac_clr), 32'd0);
    feed(0, -1, -1);
    wait_done(dc);
    check("nom_result", 32'(result), 32'd204);
    check("nom_done_lat", 32'(dc - c0), 32'd12);
    check("nom_en_pulses", 32'(en_since_clr), 32'd8);
    check("nom_clr_pulses", 32'(clr_total - clr0), 32'd1);
    check("nom_clr_cycle", 32'(last_clr_cyc - c0), 32'd2);
    check("nom_first_en", 32'(first_en_cyc - c0), 32'd3);
    check("nom_busy_done", 32'(busy), 32'd0);
    check("nom_ready_done", 32'(up.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("nom_result_hold", 32'(result), 32'd204);

    // Restart straight from DONE with constant vectors.
    for (int i = 0; i < 8; i++) begin
      va[i] = 8'd2;
      vb[i] = 8'd3;
    end
    dir0 = done_in_run;
    pulse_start(c0);
    check("rs_done_cleared", 32'(done), 32'd0);
    check("rs_result_cleared", 32'(result), 32'd0);
    feed(0, -1, -1);
    check("rs_done_low_run", 32'(done_in_run - dir0), 32'd0);
    wait_done(dc);
    check("rs_result", 32'(result), 32'd48);
    check("rs_clr_cycle", 32'(last_clr_cyc - c0), 32'd2);
    check("rs_clr_before_en", 32'(first_en_cyc > last_clr_cyc), 32'd1);

    // Bubbles: in_valid toggles every cycle.
    load_ramp();
    hold0 = hold_errs;
    pulse_start(c0);
    feed(1, -1, -1);
    wait_done(dc);
    check("bub_result", 32'(result), 32'd204);
    check("bub_en_pulses", 32'(en_since_clr), 32'd8);
    check("bub_hold", 32'(hold_errs - hold0), 32'd0);

    // Largest operands: the full accumulator width is needed.
    for (int i = 0; i < 8; i++) begin
      va[i] = 8'hFF;
      vb[i] = 8'hFF;
    end
    pulse_start(c0);
    feed(0, -1, -1);
    wait_done(dc);
    check("ovf_result", 32'(result), 32'h0007F008);

    // start raised mid-RUN must not restart or add a clear.
    load_ramp();
    clr0 = clr_total;
    pulse_start(c0);
    feed(0, 4, -1);
    wait_done(dc);
    check("ign_clr_pulses", 32'(clr_total - clr0), 32'd1);
    check("ign_result", 32'(result), 32'd204);
    check("ign_done_lat", 32'(dc - c0), 32'd12);

    // Reset after five beats, then a clean run.
    load_ramp();
    pulse_start(c0);
    feed(0, -1, 5);
    check("mr_rst_taken", 32'(rst), 32'd1);
    check("mr_in_ready", 32'(up.in_ready), 32'd0);
    check("mr_mac_en", 32'(mac_en), 32'd0);
    check("mr_mac_clr", 32'(mac_clr), 32'd0);
    check("mr_mac_a", 32'(mac_a), 32'd0);
    check("mr_mac_b", 32'(mac_b), 32'd0);
    check("mr_result", 32'(result), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    up.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mr_idle_ready", 32'(up.in_ready), 32'd0);
    check("mr_idle_busy", 32'(busy), 32'd0);
    pulse_start(c0);
    feed(0, -1, -1);
    wait_done(dc);
    check("mr_rerun_result", 32'(result), 32'd204);
    check("mr_rerun_en", 32'(en_since_clr), 32'd8);
    check("mr_rerun_lat", 32'(dc - c0), 32'd12);

    check("never_en_and_clr", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
